branch_update_queue: RTL and testbench
======================================

Name: branch_update_queue

Overview:
Buffers resolved-branch outcomes from the execute stage and drains them, one per cycle in program order, onto the branch_update_t update bus consumed by the local/global/tournament predictors. It decouples execute-stage resolution from predictor table writes, so predictor update can be stalled (e.g. table port conflict with fetch) without back-pressuring execute until the queue fills. It also keeps a saturating mispredict statistic.

Parameters:
ADDR_WIDTH, 32, PC width; matches addr_t.
DEPTH, 4, queue entries; power of two, >= 2.
CNT_WIDTH, 16, width of mispredict statistic counter.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
in_valid_i  input  1  execute presents a resolved conditional branch.
in_ready_o  output  1  queue can accept this cycle.
in_pc_i  input  ADDR_WIDTH (addr_t)  branch PC.
in_taken_i  input  1  actual branch direction.
in_mispredict_i  input  1  branch was mispredicted.
stall_i  input  1  predictors cannot accept an update this cycle.
flush_i  input  1  discard all queued entries.
update_o  output  branch_update_t  update bus to predictors.
count_o  output  $clog2(DEPTH)+1  current occupancy.
mispredict_cnt_o  output  CNT_WIDTH  accepted mispredicts, saturating.

Behaviour:
- Reset (rst_i high, async): read ptr, write ptr and occupancy = 0; mispredict_cnt_o = 0; update_o.update_valid = 0; in_ready_o = 1; count_o = 0. Entry storage needs no reset.
- Circular FIFO of DEPTH entries {pc, taken}. Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is a separate counter, 0..DEPTH.
- in_ready_o = (count < DEPTH) && !flush_i. It is combinational and must not depend on in_valid_i.
- Enqueue fires on in_valid_i && in_ready_o: write the entry at the write ptr, then advance the write ptr.
- Head drive (combinational from the head entry):
  - update_o.update_valid = (count != 0) && !stall_i && !flush_i.
  - update_o.is_branch = update_valid.
  - update_o.update_pc = head pc.
  - update_o.actual_taken = head taken.
  - Any other branch_update_t fields are driven to 0.
- Dequeue fires when update_o.update_valid = 1; advance the read ptr.
- Latency: an entry enqueued at edge N is visible on update_o in cycle N+1 at the earliest. There is no input-to-output bypass.
- Enqueue and dequeue in the same cycle: occupancy unchanged; both pointers advance.
- Full (count = DEPTH): in_ready_o = 0 even if a dequeue happens that cycle. No fall-through is permitted.
- Empty: update_valid = 0; update_pc and actual_taken are don't-care.
- stall_i: holds the head and leaves enqueue unaffected. Entries are never lost or reordered.
- flush_i (synchronous):
  - At the next edge, read ptr = write ptr and count = 0.
  - The same-cycle enqueue is blocked (in_ready_o = 0) and no update is emitted that cycle.
  - mispredict_cnt_o is not cleared.
- Mispredict counter: increments by 1 on each accepted enqueue with in_mispredict_i = 1. It saturates at 2^CNT_WIDTH-1 and never wraps. It is cleared only by reset.
- Reset mid-operation: all queued entries are discarded immediately and update_valid drops asynchronously.
- Ordering: strictly FIFO; dequeue order equals acceptance order.

Test Plan:
- Basic: enqueue PC 0x100 taken, stall_i=0 -> next cycle update_valid=1, is_branch=1, update_pc=0x100, actual_taken=1; count returns to 0 one cycle later.
- Fill/back-pressure: stall_i=1, enqueue 4 entries (PCs 0x10,0x14,0x18,0x1C) -> count_o=4 and in_ready_o=0; a 5th in_valid_i is not accepted. Release stall -> 4 updates in order on consecutive cycles; in_ready_o=1 once count<4.
- Simultaneous enq/deq at count=2 -> count stays 2; order preserved across pointer wrap for 10 streamed entries.
- Flush with 3 queued and in_valid_i=1 -> in_ready_o=0 and update_valid=0 that cycle; next cycle count_o=0 and no stale update ever appears.
- Mispredict saturation with CNT_WIDTH=2: 5 accepted mispredicts -> mispredict_cnt_o=3. A flush leaves it at 3; a mispredict offered while full (not accepted) does not count.
- Async reset asserted mid-drain with 2 entries queued -> update_valid=0 and count_o=0 immediately, before the next clock edge; normal operation resumes after deassertion.

Source files
------------

// File: rtl/branch_update_queue.sv
// branch_update_queue: FIFO of resolved branches that drains one update per cycle
// to the predictors, with a saturating mispredict statistic.
package branch_update_pkg;
    typedef logic [31:0] addr_t;
    typedef struct packed {
        logic  update_valid;
        logic  is_branch;
        addr_t update_pc;
        logic  actual_taken;
        logic  is_call;
        logic  is_return;
    } branch_update_t;
endpackage

module branch_update_queue
    import branch_update_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDR_WIDTH-1:0]    in_pc_i,
    input  logic                     in_taken_i,
    input  logic                     in_mispredict_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output branch_update_t           update_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_WIDTH-1:0]     mispredict_cnt_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
    logic [DEPTH-1:0]      taken_mem;
    logic                  enq, deq;

    // Full blocks acceptance even when the head drains this cycle: no fall-through.
    assign in_ready_o = (count < (PW+1)'(DEPTH)) && !flush_i;
    assign enq        = in_valid_i && in_ready_o;
    assign deq        = (count != '0) && !stall_i && !flush_i;
    assign count_o    = count;

    always_comb begin
        update_o              = '0;
        update_o.update_valid = deq;
        update_o.is_branch    = deq;
        update_o.update_pc    = addr_t'(pc_mem[rd_ptr]);
        update_o.actual_taken = taken_mem[rd_ptr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq);
            rd_ptr <= flush_i ? wr_ptr : rd_ptr + PW'(deq);
            count  <= flush_i ? '0 : count + (PW+1)'(enq) - (PW+1)'(deq);
            if (enq && in_mispredict_i && mispredict_cnt_o != '1)
                mispredict_cnt_o <= mispredict_cnt_o + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wr_ptr]    <= in_pc_i;
            taken_mem[wr_ptr] <= in_taken_i;
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed table plus hand sequences for wrap, flush and async reset.
module tb_branch_update_queue;
    import branch_update_pkg::*;

    logic           clk = 0, rst = 1;
    logic           in_valid = 0, in_taken = 0, in_mispredict = 0, stall = 0, flush = 0;
    logic [31:0]    in_pc = '0;
    logic           in_ready;
    branch_update_t upd;
    logic [2:0]     count;
    logic [1:0]     mcnt;
    int             total = 0, passed = 0;

    branch_update_queue #(.ADDR_WIDTH(32), .DEPTH(4), .CNT_WIDTH(2)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_taken_i(in_taken), .in_mispredict_i(in_mispredict),
        .stall_i(stall), .flush_i(flush), .update_o(upd), .count_o(count),
        .mispredict_cnt_o(mcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        tk, mp, st, fl;
        logic        rdy, uv;
        logic [31:0] upc;
        logic        utk;
        int          cnt, mc;
    } vec_t;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic mp,
                         input logic st, input logic fl);
        in_valid = v; in_pc = pc; in_taken = tk; in_mispredict = mp; stall = st; flush = fl;
    endtask

    vec_t tbl[23];
    logic [31:0] q[$];
    logic [31:0] exp_pc;

    initial begin
        // v  pc        tk mp st fl | rdy uv upc       utk cnt mc
        tbl[0]  = '{1, 32'h100, 1, 0, 0, 0, 1, 0, 32'h0,   0, 0, 0};
        tbl[1]  = '{0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h100, 1, 1, 0};
        tbl[2]  = '{0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 0};
        tbl[3]  = '{1, 32'h10,  0, 1, 1, 0, 1, 0, 32'h0,   0, 0, 0};
        tbl[4]  = '{1, 32'h14,  1, 1, 1, 0, 1, 0, 32'h0,   0, 1, 1};
        tbl[5]  = '{1, 32'h18,  0, 0, 1, 0, 1, 0, 32'h0,   0, 2, 2};
        tbl[6]  = '{1, 32'h1C,  1, 0, 1, 0, 1, 0, 32'h0,   0, 3, 2};
        tbl[7]  = '{1, 32'h20,  0, 1, 1, 0, 0, 0, 32'h0,   0, 4, 2};
        tbl[8]  = '{1, 32'h24,  0, 1, 0, 0, 0, 1, 32'h10,  0, 4, 2};
        tbl[9]  = '{0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h14,  1, 3, 2};
        tbl[10] = '{0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h18,  0, 2, 2};
        tbl[11] = '{0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h1C,  1, 1, 2};
        tbl[12] = '{0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 2};
        tbl[13] = '{1, 32'h30,  1, 1, 0, 0, 1, 0, 32'h0,   0, 0, 2};
        tbl[14] = '{1, 32'h34,  0, 1, 1, 0, 1, 0, 32'h0,   0, 1, 3};
        tbl[15] = '{1, 32'h38,  1, 1, 0, 0, 1, 1, 32'h30,  1, 2, 3};
        tbl[16] = '{1, 32'h3C,  0, 0, 1, 0, 1, 0, 32'h0,   0, 2, 3};
        tbl[17] = '{1, 32'h40,  1, 1, 0, 1, 0, 0, 32'h0,   0, 3, 3};
        tbl[18] = '{0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 3};
        tbl[19] = '{0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 3};
        tbl[20] = '{1, 32'h44,  1, 0, 0, 0, 1, 0, 32'h0,   0, 0, 3};
        tbl[21] = '{0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h44,  1, 1, 3};
        tbl[22] = '{0, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 3};

        #1;
        chk("reset_uv", -1, 32'(upd.update_valid), 0);
        chk("reset_ready", -1, 32'(in_ready), 1);
        chk("reset_count", -1, 32'(count), 0);
        chk("reset_mcnt", -1, 32'(mcnt), 0);
        repeat (2) @(negedge clk);
        rst = 0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].pc, tbl[i].tk, tbl[i].mp, tbl[i].st, tbl[i].fl);
            #1;
            chk("ready", i, 32'(in_ready), 32'(tbl[i].rdy));
            chk("update_valid", i, 32'(upd.update_valid), 32'(tbl[i].uv));
            chk("is_branch", i, 32'(upd.is_branch), 32'(tbl[i].uv));
            chk("count", i, 32'(count), 32'(tbl[i].cnt));
            chk("mcnt", i, 32'(mcnt), 32'(tbl[i].mc));
            if (tbl[i].uv) begin
                chk("update_pc", i, upd.update_pc, tbl[i].upc);
                chk("actual_taken", i, 32'(upd.actual_taken), 32'(tbl[i].utk));
            end
        end

        // Stream 10 entries through at steady occupancy 2, crossing the pointer wrap.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1, 32'h200 + 32'(4*i), 0, 0, 1, 0);
            q.push_back(32'h200 + 32'(4*i));
        end
        for (int i = 2; i < 12; i++) begin
            @(negedge clk);
            drive(1, 32'h200 + 32'(4*i), 0, 0, 0, 0);
            #1;
            chk("stream_count", i, 32'(count), 2);
            chk("stream_uv", i, 32'(upd.update_valid), 1);
            exp_pc = q.pop_front();
            chk("stream_pc", i, upd.update_pc, exp_pc);
            q.push_back(32'h200 + 32'(4*i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0);
            #1;
            exp_pc = q.pop_front();
            chk("drain_pc", i, upd.update_pc, exp_pc);
        end
        @(negedge clk);
        #1;
        chk("drain_empty", 0, 32'(upd.update_valid), 0);

        // Async reset mid-drain with two entries queued.
        @(negedge clk); drive(1, 32'h300, 1, 0, 1, 0);
        @(negedge clk); drive(1, 32'h304, 0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_uv", 0, 32'(upd.update_valid), 1);
        chk("pre_rst_count", 0, 32'(count), 2);
        #1 rst = 1;
        #1;
        chk("async_rst_uv", 0, 32'(upd.update_valid), 0);
        chk("async_rst_count", 0, 32'(count), 0);
        chk("async_rst_mcnt", 0, 32'(mcnt), 0);
        chk("async_rst_ready", 0, 32'(in_ready), 1);
        @(negedge clk); rst = 0;
        drive(1, 32'h308, 1, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("resume_uv", 0, 32'(upd.update_valid), 1);
        chk("resume_pc", 0, upd.update_pc, 32'h308);
        chk("resume_taken", 0, 32'(upd.actual_taken), 1);
        chk("resume_mcnt", 0, 32'(mcnt), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
